spi_miso_reader: RTL and testbench

//  SPI-master receive path for the uALFAT SD controller: the read-direction counterpart of spi_contlr.

---
 rtl/spi_miso_reader.sv | 170 +++++++++++++++++
 tb/tb_spi_miso_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_miso_reader.sv
// SPI-master receive path: requests the shared SPI bus, clocks bytes in on MISO
// (mode 0, MSB first, MOSI held low) and queues them in a first-word-fall-through FIFO.
module spi_miso_reader #(
  parameter int CLK_DIV    = 4,
  parameter int SSEL_SETUP = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               bus_req,
  input  logic               bus_gnt,
  input  logic               SPI_DATARDY,
  input  logic               SPI_BUSY,
  input  logic               SPI_MISO,
  output logic               SPI_SCK,
  output logic               SPI_MOSI,
  output logic               SPI_SSEL,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   rx_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int SW    = (SSEL_SETUP > 1) ? $clog2(SSEL_SETUP) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, SETUP, WAITB, SHIFT, STORE, GAP
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [SW-1:0]     setup_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              gnt_lost;
  logic              sck;
  logic              ssel;
  logic              req;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               push;
  logic               pop;

  assign full = count[FIFO_AW];
  assign push = (state == STORE);
  assign pop  = rx_ready && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ssel      <= 1'b1;
      sck       <= 1'b0;
      req       <= 1'b0;
      div_cnt   <= '0;
      setup_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      gnt_lost  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt_lost <= 1'b0;
          if (enable && SPI_DATARDY && !full) begin
            req   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (!enable) begin
            req   <= 1'b0;
            state <= IDLE;
          end else if (bus_gnt) begin
            ssel      <= 1'b0;
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (!bus_gnt) gnt_lost <= 1'b1;
          if (setup_cnt == SW'(SSEL_SETUP - 1)) state <= WAITB;
          else setup_cnt <= setup_cnt + 1'b1;
        end
        WAITB: begin
          if (!bus_gnt || gnt_lost) begin
            ssel  <= 1'b1;
            req   <= 1'b0;
            state <= IDLE;
          end else if (!SPI_BUSY && !full) begin
            // the WAITB exit cycle already counts as the first SCK-low cycle
            bit_cnt <= 3'd7;
            div_cnt <= DW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus_gnt) gnt_lost <= 1'b1;
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sck) begin
              sck   <= 1'b1;
              shift <= {shift[6:0], SPI_MISO};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 3'd0) state <= STORE;
              else bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STORE: begin
          if (!bus_gnt || gnt_lost) begin
            ssel  <= 1'b1;
            req   <= 1'b0;
            state <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (SPI_DATARDY && enable && bus_gnt) begin
            state <= WAITB;
          end else begin
            ssel  <= 1'b1;
            req   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus_req  = req;
  assign SPI_SCK  = sck;
  assign SPI_SSEL = ssel;
  assign SPI_MOSI = 1'b0;
  assign rx_data  = mem[rptr];
  assign rx_valid = (count != '0);
  assign rx_count = count;

endmodule

// File: tb/tb_spi_miso_reader.sv
// Directed bench for spi_miso_reader: behavioural mode-0 slave on MISO, linear stimulus,
// hand-derived expectations for timing, FIFO ordering, stalls, grant loss and reset.
module tb_spi_miso_reader;

  localparam int SEL_SSEL_LO = 0;
  localparam int SEL_SSEL_HI = 1;
  localparam int SEL_SCK_HI  = 2;
  localparam int SEL_SCK_LO  = 3;
  localparam int SEL_VALID   = 4;
  localparam int SEL_COUNT   = 5;
  localparam int SEL_RISES   = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       bus_req;
  logic       bus_gnt;
  logic       datardy;
  logic       busy;
  logic       miso = 1'b0;
  logic       sck;
  logic       mosi;
  logic       ssel;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] rx_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_miso_reader #(
    .CLK_DIV    (4),
    .SSEL_SETUP (8),
    .FIFO_AW    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .SPI_DATARDY (datardy),
    .SPI_BUSY    (busy),
    .SPI_MISO    (miso),
    .SPI_SCK     (sck),
    .SPI_MOSI    (mosi),
    .SPI_SSEL    (ssel),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_count    (rx_count)
  );

  // Slave model: presents the queue head MSB first, changes data only while SCK is low,
  // retires a byte after its 8th rising edge.
  logic [7:0] q[$];
  int         rises      = 0;
  int         busy_rises = 0;
  int         ssel_rises = 0;
  int         bitn       = 0;
  logic       sck_d      = 1'b0;
  logic       ssel_d     = 1'b1;
  logic [7:0] head;

  always @(sck or ssel) begin
    if (ssel === 1'b1) begin
      if (ssel_d === 1'b0) ssel_rises++;
      bitn = 0;
      miso = 1'b0;
    end else if (sck === 1'b1 && sck_d === 1'b0) begin
      rises++;
      if (busy) busy_rises++;
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        if (q.size() > 0) void'(q.pop_front());
      end
    end else if (sck === 1'b0) begin
      head = (q.size() > 0) ? q[0] : 8'h00;
      miso = head[3'(7 - bitn)];
    end
    sck_d  = sck;
    ssel_d = ssel;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond(input int sel, input int tgt);
    case (sel)
      SEL_SSEL_LO: return ssel === 1'b0;
      SEL_SSEL_HI: return ssel === 1'b1;
      SEL_SCK_HI:  return sck === 1'b1;
      SEL_SCK_LO:  return sck === 1'b0;
      SEL_VALID:   return rx_valid === 1'b1;
      SEL_COUNT:   return rx_count === 4'(tgt);
      SEL_RISES:   return rises >= tgt;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int tgt, input int budget, input string tag,
                          output int n);
    n = 0;
    while (!cond(sel, tgt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cond(sel, tgt)), 32'd1);
  endtask

  task automatic pop_check(input logic [7:0] exp, input string tag);
    check(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_datardy();
    datardy = 1'b1;
    @(negedge clk);
    datardy = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    int s0;

    rst = 1'b0; enable = 1'b0; bus_gnt = 1'b0; datardy = 1'b0; busy = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssel",  32'(ssel),     32'd1);
    check("rst_sck",   32'(sck),      32'd0);
    check("rst_mosi",  32'(mosi),     32'd0);
    check("rst_req",   32'(bus_req),  32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    rst = 1'b1;

    // No grant: request raised, pins stay inactive; enable drop withdraws the request
    enable = 1'b1; datardy = 1'b1;
    repeat (30) @(negedge clk);
    check("nognt_req",   32'(bus_req), 32'd1);
    check("nognt_ssel",  32'(ssel),    32'd1);
    check("nognt_rises", 32'(rises),   32'd0);
    enable = 1'b0;
    @(negedge clk);
    check("nognt_req_drop", 32'(bus_req), 32'd0);
    datardy = 1'b0;

    // Single byte 0xA5
    bus_gnt = 1'b1; enable = 1'b1;
    q.push_back(8'hA5);
    base = rises;
    pulse_datardy();
    wait_for(SEL_SSEL_LO, 0, 20, "single_ssel_low", n);
    wait_for(SEL_SCK_HI, 0, 40, "single_first_rise", n);
    check("setup_to_sck", 32'(n), 32'd12);
    wait_for(SEL_SCK_LO, 0, 20, "single_first_fall", n);
    check("sck_high_width", 32'(n), 32'd4);
    wait_for(SEL_VALID, 0, 200, "single_valid", n);
    check("single_data",  32'(rx_data),     32'h A5);
    check("single_count", 32'(rx_count),    32'd1);
    check("single_rises", 32'(rises - base), 32'd8);
    wait_for(SEL_SSEL_HI, 0, 10, "single_ssel_high", n);
    check("single_req_off", 32'(bus_req), 32'd0);
    pop_check(8'hA5, "single_pop");
    check("single_empty", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    check("empty_pop_count", 32'(rx_count), 32'd0);

    // Burst of three bytes under one SSEL assertion
    base = rises; s0 = ssel_rises;
    q.push_back(8'h01); q.push_back(8'h80); q.push_back(8'hFF);
    datardy = 1'b1;
    wait_for(SEL_RISES, base + 17, 400, "burst_third_start", n);
    datardy = 1'b0;
    wait_for(SEL_COUNT, 3, 200, "burst_count", n);
    check("burst_ssel_held", 32'(ssel_rises - s0), 32'd0);
    check("burst_ssel_low",  32'(ssel),            32'd0);
    pop_check(8'h01, "burst_b0");
    pop_check(8'h80, "burst_b1");
    pop_check(8'hFF, "burst_b2");
    wait_for(SEL_SSEL_HI, 0, 10, "burst_ssel_high", n);

    // Slave busy holds off SCK
    busy = 1'b1;
    q.push_back(8'h3C);
    base = rises;
    pulse_datardy();
    wait_for(SEL_SSEL_LO, 0, 20, "busy_ssel_low", n);
    repeat (50) @(negedge clk);
    check("busy_no_rises", 32'(rises - base), 32'd0);
    check("busy_sck_low",  32'(sck),          32'd0);
    check("busy_ssel_low", 32'(ssel),         32'd0);
    busy = 1'b0;
    wait_for(SEL_VALID, 0, 200, "busy_valid", n);
    check("busy_data",       32'(rx_data),    32'h3C);
    check("busy_rises_zero", 32'(busy_rises), 32'd0);
    pop_check(8'h3C, "busy_pop");
    wait_for(SEL_SSEL_HI, 0, 10, "busy_ssel_high", n);

    // FIFO full: stall in WAITB, pops release one byte each, push+pop keeps count
    base = rises;
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h10 + i));
    datardy = 1'b1;
    wait_for(SEL_COUNT, 8, 2000, "full_reach8", n);
    repeat (200) @(negedge clk);
    check("full_count", 32'(rx_count),     32'd8);
    check("full_ssel",  32'(ssel),         32'd0);
    check("full_sck",   32'(sck),          32'd0);
    check("full_rises", 32'(rises - base), 32'd64);
    pop_check(8'h10, "full_pop0");
    wait_for(SEL_COUNT, 8, 300, "full_refill", n);
    check("full_ninth_rises", 32'(rises - base), 32'd72);
    pop_check(8'h11, "full_pop1");
    wait_for(SEL_RISES, base + 73, 100, "full_tenth_start", n);
    datardy = 1'b0;
    wait_for(SEL_RISES, base + 80, 100, "full_tenth_bits", n);
    wait_for(SEL_SCK_LO, 0, 10, "full_tenth_end", n);
    check("pushpop_before", 32'(rx_count), 32'd7);
    check("pushpop_head",   32'(rx_data),  32'h12);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("pushpop_count",    32'(rx_count), 32'd7);
    check("pushpop_new_head", 32'(rx_data),  32'h13);
    for (int i = 3; i < 10; i++) pop_check(8'(8'h10 + i), "full_drain");
    check("full_drained", 32'(rx_count), 32'd0);
    wait_for(SEL_SSEL_HI, 0, 10, "full_ssel_high", n);

    // Grant lost mid-byte: byte completes, then bus released
    q.push_back(8'h5A); q.push_back(8'h77);
    base = rises;
    datardy = 1'b1;
    wait_for(SEL_RISES, base + 3, 100, "gnt_mid_byte", n);
    bus_gnt = 1'b0;
    wait_for(SEL_COUNT, 1, 200, "gnt_byte_done", n);
    check("gnt_data", 32'(rx_data), 32'h5A);
    wait_for(SEL_SSEL_HI, 0, 5, "gnt_ssel_high", n);
    repeat (100) @(negedge clk);
    check("gnt_rises",  32'(rises - base), 32'd8);
    check("gnt_ssel",   32'(ssel),         32'd1);
    check("gnt_rereq",  32'(bus_req),      32'd1);
    enable = 1'b0; datardy = 1'b0;
    repeat (2) @(negedge clk);
    check("gnt_req_off", 32'(bus_req), 32'd0);

    // Reset mid-SHIFT with a byte still in the FIFO
    q.delete();
    q.push_back(8'hC3);
    bus_gnt = 1'b1; enable = 1'b1;
    base = rises;
    pulse_datardy();
    wait_for(SEL_RISES, base + 3, 100, "rst_mid_shift", n);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ssel",  32'(ssel),     32'd1);
    check("rstmid_sck",   32'(sck),      32'd0);
    check("rstmid_req",   32'(bus_req),  32'd0);
    check("rstmid_count", 32'(rx_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    q.push_back(8'h96);
    base = rises;
    pulse_datardy();
    wait_for(SEL_VALID, 0, 200, "post_rst_valid", n);
    check("post_rst_data",  32'(rx_data),     32'h96);
    check("post_rst_rises", 32'(rises - base), 32'd8);
    pop_check(8'h96, "post_rst_pop");
    wait_for(SEL_SSEL_HI, 0, 10, "post_rst_ssel_high", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
